// File: rtl/time_entry_pkg.sv
// time_entry_pkg: shared types and constants for the countdown time-entry block.
//   state_t           FSM state encoding (IDLE, EDIT, LOAD, RUN)
//   SEC_ONES..MIN_TENS digit indices, also the encoding of the sel output
//   BTN_*             bit positions of the conditioned button vector
//   MAX_DIGIT, MAX_SEC_TENS per-digit upper bounds
//   digit_max/inc/dec wrap-around digit arithmetic (no carry or borrow)
package time_entry_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EDIT = 2'd1,
        LOAD = 2'd2,
        RUN  = 2'd3
    } state_t;

    localparam logic [1:0] SEC_ONES = 2'd0;
    localparam logic [1:0] SEC_TENS = 2'd1;
    localparam logic [1:0] MIN_ONES = 2'd2;
    localparam logic [1:0] MIN_TENS = 2'd3;

    localparam int BTN_SEL   = 0;
    localparam int BTN_INC   = 1;
    localparam int BTN_DEC   = 2;
    localparam int BTN_GO    = 3;
    localparam int NUM_BTNS  = 4;

    localparam logic [3:0] MAX_DIGIT    = 4'd9;
    localparam logic [3:0] MAX_SEC_TENS = 4'd5;

    function automatic logic [3:0] digit_max(input logic [1:0] idx);
        return (idx == SEC_TENS) ? MAX_SEC_TENS : MAX_DIGIT;
    endfunction

    // >= rather than == so an out-of-range value can only ever fall back to 0
    function automatic logic [3:0] digit_inc(input logic [3:0] d, input logic [1:0] idx);
        return (d >= digit_max(idx)) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [3:0] digit_dec(input logic [3:0] d, input logic [1:0] idx);
        return (d == 4'd0 || d > digit_max(idx)) ? digit_max(idx) : d - 4'd1;
    endfunction

endpackage

// File: rtl/time_entry_btn_cond.sv
// btn_cond: conditions one raw push button into a single-cycle action pulse.
//   clk, reset  clock and synchronous active-high reset
//   raw         asynchronous button level
//   pulse       one-cycle high on each accepted press (combinational from flops)
// Macro TIME_ENTRY_DEBOUNCE_EN adds a stability filter of DEBOUNCE_CYCLES cycles
// between the synchroniser and the edge detector.
module btn_cond #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic pulse
);

    logic       sync1, sync2;
    logic       lvl, lvl_d;
    logic       armed;
    logic [1:0] vld_pipe;

    // vld_pipe marks when sync2 reflects a post-reset sample of raw. The
    // detector arms only after a genuinely low level has been seen, so a
    // button held through reset release produces no action.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            lvl_d    <= 1'b0;
            armed    <= 1'b0;
            vld_pipe <= 2'b00;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            lvl_d    <= lvl;
            vld_pipe <= {vld_pipe[0], 1'b1};
            if (vld_pipe[1] && !sync2 && !lvl)
                armed <= 1'b1;
        end
    end

`ifdef TIME_ENTRY_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CNT_W-1:0] cnt;

    // Accept a new level only after it has differed from the current one for
    // DEBOUNCE_CYCLES consecutive cycles; any bounce back restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            lvl <= 1'b0;
            cnt <= '0;
        end else if (sync2 == lvl) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            lvl <= sync2;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
    assign lvl = sync2;
`endif

    assign pulse = lvl & ~lvl_d & armed;

endmodule

// File: rtl/time_entry.sv
// time_entry: four-digit MM:SS preset entry and run control for a downstream
// BCD countdown chain.
//   clk, reset                       clock, synchronous active-high reset
//   btn_sel/inc/dec/go               raw buttons (select digit, +1, -1, start/stop)
//   done                             terminal-count pulse from the counter chain
//   min_tens..sec_ones               registered BCD preset digits
//   load                             one-cycle load strobe
//   run                              count-enable level
//   sel                              selected digit (0=sec_ones .. 3=min_tens)
//   editing                          high while in EDIT (digit blink)
// Optional macro: TIME_ENTRY_DEBOUNCE_EN enables per-button debounce.
module time_entry
    import time_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_sel,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       btn_go,
    input  logic       done,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       load,
    output logic       run,
    output logic [1:0] sel,
    output logic       editing
);

    logic [NUM_BTNS-1:0]      raw;
    logic [NUM_BTNS-1:0]      edges;
    logic [3:0][3:0]          digits;
    state_t                   state;

    assign raw[BTN_SEL] = btn_sel;
    assign raw[BTN_INC] = btn_inc;
    assign raw[BTN_DEC] = btn_dec;
    assign raw[BTN_GO]  = btn_go;

    btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn [NUM_BTNS-1:0] (
        .clk   (clk),
        .reset (reset),
        .raw   (raw),
        .pulse (edges)
    );

    assign sec_ones = digits[SEC_ONES];
    assign sec_tens = digits[SEC_TENS];
    assign min_ones = digits[MIN_ONES];
    assign min_tens = digits[MIN_TENS];

    // Button priority go > sel > inc > dec: the if/else chains below discard
    // any lower-priority edge arriving in the same cycle, even when the
    // winning edge itself has no effect (go with an all-zero preset).
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            digits  <= '0;
            sel     <= SEC_ONES;
            load    <= 1'b0;
            run     <= 1'b0;
            editing <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (edges[BTN_GO]) begin
                        if (digits != '0) begin
                            state <= LOAD;
                            load  <= 1'b1;
                        end
                    end else if (edges[BTN_SEL]) begin
                        state   <= EDIT;
                        sel     <= SEC_ONES;
                        editing <= 1'b1;
                    end
                end
                EDIT: begin
                    if (edges[BTN_GO]) begin
                        state   <= LOAD;
                        load    <= 1'b1;
                        editing <= 1'b0;
                    end else if (edges[BTN_SEL]) begin
                        sel <= sel + 2'd1;
                    end else if (edges[BTN_INC]) begin
                        digits[sel] <= digit_inc(digits[sel], sel);
                    end else if (edges[BTN_DEC]) begin
                        digits[sel] <= digit_dec(digits[sel], sel);
                    end
                end
                LOAD: begin
                    state <= RUN;
                    load  <= 1'b0;
                    run   <= 1'b1;
                end
                RUN: begin
                    // done wins over a simultaneous go: the count has expired
                    if (done) begin
                        state  <= IDLE;
                        run    <= 1'b0;
                        digits <= '0;
                    end else if (edges[BTN_GO]) begin
                        state <= IDLE;
                        run   <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    load    <= 1'b0;
                    run     <= 1'b0;
                    editing <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/time_entry.md
TIME_ENTRY -- requirements
Module: time_entry

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: number of consecutive stable clk cycles required to accept a button level (used only with TIME_ENTRY_DEBOUNCE_EN).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 btn_sel  input  1  raw button that advances the selected digit.
REQ-005 btn_inc  input  1  raw button that increments the selected digit.
REQ-006 btn_dec  input  1  raw button that decrements the selected digit.
REQ-007 btn_go  input  1  raw button that starts or stops the countdown.
REQ-008 done  input  1  terminal-count pulse from the downstream counter chain.
REQ-009 min_tens, min_ones, sec_tens, sec_ones  output  4 each  BCD preset digits driven to the downstream counters' data inputs.
REQ-010 load  output  1  one-cycle load strobe to the downstream counters.
REQ-011 run  output  1  count-enable level to the downstream chain.
REQ-012 sel  output  2  selected digit: 0=sec_ones, 1=sec_tens, 2=min_ones, 3=min_tens.
REQ-013 editing  output  1  high while in EDIT; drives the digit-blink display logic.

Function
REQ-014 Each button passes through 2-flop synchronisation and rising-edge detection; one press yields exactly one action, whatever the hold time.
REQ-015 Without debounce, the action takes effect on the 3rd rising clk edge after the raw button first meets setup high.
REQ-016 FSM states: IDLE, EDIT, LOAD, RUN; all outputs are registered.
REQ-017 IDLE: sel edge -> EDIT with sel=0; go edge with any digit nonzero -> LOAD; go edge with all digits zero -> stay in IDLE; inc and dec edges are ignored.
REQ-018 EDIT: sel edge advances sel 0->1->2->3->0; inc and dec modify only the selected digit; go edge -> LOAD.
REQ-019 Digit range: sec_tens 0..5; all other digits 0..9.
REQ-020 inc wraps from the maximum to 0 (9->0; sec_tens 5->0); dec wraps from 0 to the maximum (0->9; sec_tens 0->5). There is no carry or borrow into neighbouring digits.
REQ-021 No digit register ever holds a value above its maximum, so the downstream error path is never triggered.
REQ-022 LOAD: load=1 for exactly one cycle, digits held, then -> RUN unconditionally.
REQ-023 RUN: run=1; go edge -> IDLE with run=0 (pause); done=1 -> IDLE with run=0 and all four digits cleared to 0.
REQ-024 If go edge and done arrive in the same RUN cycle, done takes priority (digits cleared).
REQ-025 Simultaneous button edges in the same cycle: priority go > sel > inc > dec; lower-priority edges in that cycle are discarded.
REQ-026 done is ignored outside RUN; in IDLE, EDIT and LOAD, run=0.
REQ-027 editing=1 exactly when the state is EDIT.

Reset
REQ-028 On reset: state=IDLE; all digits=0; sel=0; load=0; run=0; editing=0; synchroniser, edge and debounce state cleared.
REQ-029 Reset asserted during LOAD or RUN takes effect at the next edge; no further load pulse is emitted and run drops in that cycle.
REQ-030 A button held high through reset release does not produce an action until it is released and pressed again.

Configuration
REQ-031 Macro TIME_ENTRY_DEBOUNCE_EN defined: the synchronised level must be stable for DEBOUNCE_CYCLES cycles before edge detection, adding DEBOUNCE_CYCLES cycles of latency; glitches shorter than that produce no action.
REQ-032 Macro TIME_ENTRY_DEBOUNCE_EN undefined: synchronisation and edge detection only; DEBOUNCE_CYCLES is unused.

Structure
REQ-033 Shared package time_entry_pkg holds the state enum, the digit-index constants (SEC_ONES..MIN_TENS), and MAX_DIGIT=9 and MAX_SEC_TENS=5.
REQ-034 One sub-module, btn_cond (synchroniser, optional debounce, rising-edge pulse), is instantiated four times.

Verification
REQ-035 Reset, then sel, then inc x3 -> sec_ones=3, sel=0, editing=1; all other digits 0.
REQ-036 In EDIT: sel to sel=1, then inc x6 -> sec_tens steps 1,2,3,4,5,0; then dec once -> sec_tens=5.
REQ-037 Digits set to 1,2,3,4 (min_tens..sec_ones), then go -> exactly one load pulse with data 1234, then run=1 on the following cycle; pulse done -> run=0, state IDLE, all digits 0.
REQ-038 All digits 0 in IDLE, then go -> no load pulse, run stays 0.
REQ-039 Same-cycle go and inc edges in EDIT -> LOAD taken and the digit unchanged; same-cycle go and done in RUN -> digits cleared.
REQ-040 With TIME_ENTRY_DEBOUNCE_EN and DEBOUNCE_CYCLES=16: a 10-cycle glitch on btn_inc produces no change; a 20-cycle press produces exactly one increment.
